// File: rtl/exec_writeback_if.sv
// Decode <-> execute/write-back boundary: decoded operands and control flow one way,
// stall, redirect and write-back flow the other.
interface exec_writeback_if;
  logic        in_valid;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_rd1;
  logic [31:0] in_rd2;
  logic [31:0] in_imm;
  logic [4:0]  in_write_reg;
  logic        in_reg_wren;
  logic        in_branch;
  logic        in_load;
  logic        in_mem_wren;
  logic        in_alu_src;
  logic [4:0]  in_alu_op;
  logic [4:0]  in_pc;
  logic        stall;
  logic [4:0]  jump_pc;
  logic        should_jump;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_wren;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd1, in_rd2, in_imm, in_write_reg, in_reg_wren,
           in_branch, in_load, in_mem_wren, in_alu_src, in_alu_op, in_pc,
    input  stall, jump_pc, should_jump, wb_reg, wb_data, wb_wren
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd1, in_rd2, in_imm, in_write_reg, in_reg_wren,
           in_branch, in_load, in_mem_wren, in_alu_src, in_alu_op, in_pc,
    output stall, jump_pc, should_jump, wb_reg, wb_data, wb_wren
  );
endinterface

// File: rtl/exec_writeback.sv
// Execute / memory / write-back back end of the 5-bit-PC CPU: ALU with forwarding,
// branch resolution with a 2-slot squash shadow, load-use stall and an internal data RAM.
module exec_writeback #(
  parameter int DMEM_AW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_writeback_if.slave bus
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_XOR = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7,
                         OP_SLT = 5'd8, OP_SLTU = 5'd9,
                         OP_BEQ = 5'd16, OP_BNE = 5'd17, OP_BLT = 5'd18, OP_BGE = 5'd19;

  logic        s1_valid, s1_reg_wren, s1_branch, s1_load, s1_mem_wren, s1_alu_src;
  logic [4:0]  s1_rs1, s1_rs2, s1_rd, s1_op, s1_pc;
  logic [31:0] s1_rd1, s1_rd2, s1_imm;

  logic        s2_valid, s2_reg_wren, s2_load, s2_mem_wren;
  logic [4:0]  s2_rd;
  logic [31:0] s2_result, s2_store;

  logic        s3_valid, s3_reg_wren, s3_load;
  logic [4:0]  s3_rd;
  logic [31:0] s3_result, s3_rdata;

  logic        should_jump_q;
  logic [4:0]  jump_pc_q;

  logic [31:0] dmem [0:(1<<DMEM_AW)-1];
  logic [DMEM_AW-1:0] s2_addr;

  logic        s2_fwd_ok, wb_wren, taken, squash, stall;
  logic [31:0] wb_data, op_a, fwd_rd2, op_b, alu_y;
  logic        br_cond;

  assign wb_wren   = s3_valid & s3_reg_wren & (s3_rd != 5'd0);
  assign wb_data   = s3_load ? s3_rdata : s3_result;
  // A load in S2 has no data yet; the load-use stall keeps dependents from needing it.
  assign s2_fwd_ok = s2_valid & s2_reg_wren & ~s2_load;

  always_comb begin
    op_a = s1_rd1;
    if (s1_rs1 != 5'd0 && s2_fwd_ok && s2_rd == s1_rs1)      op_a = s2_result;
    else if (s1_rs1 != 5'd0 && wb_wren && s3_rd == s1_rs1)  op_a = wb_data;
    fwd_rd2 = s1_rd2;
    if (s1_rs2 != 5'd0 && s2_fwd_ok && s2_rd == s1_rs2)      fwd_rd2 = s2_result;
    else if (s1_rs2 != 5'd0 && wb_wren && s3_rd == s1_rs2)  fwd_rd2 = wb_data;
  end

  assign op_b = s1_alu_src ? s1_imm : fwd_rd2;

  always_comb begin
    alu_y = 32'd0;
    case (s1_op)
      OP_ADD:  alu_y = op_a + op_b;
      OP_SUB:  alu_y = op_a - op_b;
      OP_AND:  alu_y = op_a & op_b;
      OP_OR:   alu_y = op_a | op_b;
      OP_XOR:  alu_y = op_a ^ op_b;
      OP_SLL:  alu_y = op_a << op_b[4:0];
      OP_SRL:  alu_y = op_a >> op_b[4:0];
      OP_SRA:  alu_y = $signed(op_a) >>> op_b[4:0];
      OP_SLT:  alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_y = {31'd0, op_a < op_b};
      default: alu_y = 32'd0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (s1_op)
      OP_BEQ:  br_cond = (op_a == op_b);
      OP_BNE:  br_cond = (op_a != op_b);
      OP_BLT:  br_cond = ($signed(op_a) <  $signed(op_b));
      OP_BGE:  br_cond = ($signed(op_a) >= $signed(op_b));
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = s1_valid & s1_branch & br_cond;
  // Shadow: the instruction entering on the resolve edge and the one presented during the pulse.
  assign squash = taken | should_jump_q;
  assign stall  = s1_valid & s1_load & (s1_rd != 5'd0) & bus.in_valid &
                  ((s1_rd == bus.in_rs1) | (s1_rd == bus.in_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_reg_wren <= 1'b0; s1_branch <= 1'b0; s1_load <= 1'b0;
      s1_mem_wren <= 1'b0; s1_alu_src <= 1'b0;
      s1_rs1 <= '0; s1_rs2 <= '0; s1_rd <= '0; s1_op <= '0; s1_pc <= '0;
      s1_rd1 <= '0; s1_rd2 <= '0; s1_imm <= '0;
      s2_valid <= 1'b0; s2_reg_wren <= 1'b0; s2_load <= 1'b0; s2_mem_wren <= 1'b0;
      s2_rd <= '0; s2_result <= '0; s2_store <= '0;
      s3_valid <= 1'b0; s3_reg_wren <= 1'b0; s3_load <= 1'b0;
      s3_rd <= '0; s3_result <= '0;
      should_jump_q <= 1'b0; jump_pc_q <= '0;
    end else begin
      s1_valid    <= bus.in_valid & ~stall & ~squash;
      s1_reg_wren <= bus.in_reg_wren;
      s1_branch   <= bus.in_branch;
      s1_load     <= bus.in_load;
      s1_mem_wren <= bus.in_mem_wren;
      s1_alu_src  <= bus.in_alu_src;
      s1_rs1      <= bus.in_rs1;
      s1_rs2      <= bus.in_rs2;
      s1_rd       <= bus.in_write_reg;
      s1_op       <= bus.in_alu_op;
      s1_pc       <= bus.in_pc;
      s1_rd1      <= bus.in_rd1;
      s1_rd2      <= bus.in_rd2;
      s1_imm      <= bus.in_imm;

      s2_valid    <= s1_valid;
      s2_reg_wren <= s1_reg_wren & ~s1_branch & ~s1_mem_wren;
      s2_load     <= s1_load;
      s2_mem_wren <= s1_mem_wren;
      s2_rd       <= s1_rd;
      s2_result   <= alu_y;
      s2_store    <= fwd_rd2;

      s3_valid    <= s2_valid;
      s3_reg_wren <= s2_reg_wren;
      s3_load     <= s2_load;
      s3_rd       <= s2_rd;
      s3_result   <= s2_result;

      should_jump_q <= taken;
      if (taken) jump_pc_q <= s1_pc + s1_imm[4:0];
    end
  end

  assign s2_addr = s2_result[DMEM_AW+1:2];

  // A store in S2 writes on the same edge a following load would otherwise read, so a
  // load directly behind a store to the same word reads it one edge later and sees new data.
  always_ff @(posedge clk) begin
    if (s2_valid && s2_mem_wren) dmem[s2_addr] <= s2_store;
    s3_rdata <= dmem[s2_addr];
  end

  assign bus.stall       = stall;
  assign bus.jump_pc     = jump_pc_q;
  assign bus.should_jump = should_jump_q;
  assign bus.wb_reg      = s3_rd;
  assign bus.wb_data     = wb_data;
  assign bus.wb_wren     = wb_wren;
endmodule
